// File: rtl/ir_pkg.sv
// ir_pkg: shared types and frame-timing constants for the NEC IR transmitter.
//   ir_state_t  - transmitter FSM state encoding
//   *_UNITS     - duration of each frame segment in NEC units
//   FRAME_BITS  - payload length (address, ~address, command, ~command)
//   state_units - duration in units of a given state (bit value picks space length)
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } ir_state_t;

   localparam int unsigned LEAD_MARK_UNITS  = 16;
   localparam int unsigned LEAD_SPACE_UNITS = 8;
   localparam int unsigned ZERO_SPACE_UNITS = 1;
   localparam int unsigned ONE_SPACE_UNITS  = 3;
   localparam int unsigned STOP_UNITS       = 1;
   localparam int unsigned FRAME_BITS       = 32;

   function automatic logic [4:0] state_units(input ir_state_t s, input logic bit_val);
      logic [4:0] u;
      u = 5'd1;
      case (s)
         LEAD_MARK:  u = 5'(LEAD_MARK_UNITS);
         LEAD_SPACE: u = 5'(LEAD_SPACE_UNITS);
         BIT_MARK:   u = 5'd1;
         BIT_SPACE:  u = bit_val ? 5'(ONE_SPACE_UNITS) : 5'(ZERO_SPACE_UNITS);
         STOP_MARK:  u = 5'(STOP_UNITS);
         default:    u = 5'd1;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier with a restartable phase.
//   clk     - system clock
//   reset   - synchronous, active-low
//   restart - pulse in the cycle whose edge begins a mark
//   carrier - carrier phase for the NEXT cycle (one cycle of lookahead)
//
// The output runs one cycle ahead of the phase that should appear on the
// LED: the top registers ir_out from it, so the registered pin shows a full
// high half-period starting at the mark's first cycle. The restart edge
// itself forces the pin high; this block then supplies phases 1, 2, ...
module ir_carrier_gen #(
   parameter int unsigned CARRIER_HALF = 658
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic carrier
);

   localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         carrier <= 1'b0;
      end else if (restart) begin
         // Phase after the restart edge is cycle 1 of the mark.
         if (CARRIER_HALF == 1) begin
            cnt     <= '0;
            carrier <= 1'b0;
         end else begin
            cnt     <= CW'(1);
            carrier <= 1'b1;
         end
      end else if (cnt == CW'(CARRIER_HALF - 1)) begin
         cnt     <= '0;
         carrier <= ~carrier;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ir_transmitter.sv
// ir_transmitter: sends one NEC frame (leader, 32-bit payload, stop mark).
//   clk    - system clock
//   reset  - synchronous, active-low
//   start  - request a frame; only honoured in IDLE
//   value  - command byte, latched when start is accepted
//   ir_out - LED drive (carrier or steady 1 during marks, 0 otherwise)
//   busy   - frame in progress
//   done   - one-cycle pulse after the stop mark
module ir_transmitter
   import ir_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES  = 28125,
   parameter int unsigned CARRIER_HALF = 658,
   parameter logic [7:0]  ADDRESS      = 8'h00,
   parameter bit          MODULATE     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] value,
   output logic       ir_out,
   output logic       busy,
   output logic       done
);

   localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   ir_state_t     state, state_next;
   logic [UW-1:0] unit_cnt;
   logic [3:0]    unit_num;
   logic [4:0]    bit_idx;
   logic [31:0]   shreg;
   logic          unit_last;
   logic          state_last;
   logic          mark_next;
   logic          restart;
   logic          carrier;

   ir_carrier_gen #(
      .CARRIER_HALF(CARRIER_HALF)
   ) u_carrier (
      .clk    (clk),
      .reset  (reset),
      .restart(restart),
      .carrier(carrier)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unit_last  = (unit_cnt == UW'(UNIT_CYCLES - 1));
      state_last = unit_last &&
                   ({1'b0, unit_num} == (state_units(state, shreg[0]) - 5'd1));
      case (state)
         IDLE:       if (start)      state_next = LEAD_MARK;
         LEAD_MARK:  if (state_last) state_next = LEAD_SPACE;
         LEAD_SPACE: if (state_last) state_next = BIT_MARK;
         BIT_MARK:   if (state_last) state_next = BIT_SPACE;
         BIT_SPACE: begin
            if (state_last) begin
               state_next = (bit_idx == 5'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
            end
         end
         STOP_MARK:  if (state_last) state_next = IDLE;
         default:    state_next = IDLE;
      endcase
      mark_next = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                  (state_next == STOP_MARK);
      // Marks are always preceded by a non-mark state, so any state change
      // into a mark is a mark entry.
      restart   = mark_next && (state_next != state);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         unit_cnt <= '0;
         unit_num <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         ir_out   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         // Counters restart on the very edge that changes state, so each
         // state lasts exactly its unit count with no extra cycle.
         if ((state_next != state) || (state == IDLE)) begin
            unit_cnt <= '0;
            unit_num <= '0;
         end else if (unit_last) begin
            unit_cnt <= '0;
            unit_num <= unit_num + 4'd1;
         end else begin
            unit_cnt <= unit_cnt + UW'(1);
         end

         if ((state == IDLE) && start) begin
            shreg   <= {~value, value, ~ADDRESS, ADDRESS};
            bit_idx <= '0;
         end else if ((state == BIT_SPACE) && state_last) begin
            shreg   <= {1'b0, shreg[31:1]};
            bit_idx <= bit_idx + 5'd1;
         end

         busy <= (state_next != IDLE);
         done <= (state == STOP_MARK) && (state_next == IDLE);

         if (!mark_next) begin
            ir_out <= 1'b0;
         end else if (!MODULATE) begin
            ir_out <= 1'b1;
         end else begin
            ir_out <= restart | carrier;
         end
      end
   end

endmodule
